// File: rtl/dmem_sram_resp.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | dmem_sram_resp : single-outstanding AXI4-Lite-style data memory    |
// |                  with a fixed, programmable response latency       |
// | Revision       : 1.0                                               |
// +--------------------------------------------------------------------+
module dmem_sram_resp #(
   parameter int unsigned ADDR_W  = 8,
   parameter logic [31:0] BASE    = 32'h8000_0000,
   parameter int unsigned LATENCY = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] araddr,
   input  logic        arvalid,
   output logic        arready,
   output logic [31:0] rdata,
   output logic [1:0]  rresp,
   output logic        rvalid,
   input  logic        rready,
   input  logic [31:0] awaddr,
   input  logic        awvalid,
   output logic        awready,
   input  logic [31:0] wdata,
   input  logic [3:0]  wstrb,
   input  logic        wvalid,
   output logic        wready,
   output logic [1:0]  bresp,
   output logic        bvalid,
   input  logic        bready
);

   localparam int unsigned      CNT_W    = (LATENCY > 1) ? $clog2(LATENCY) : 1;
   localparam int unsigned      DEPTH    = 1 << ADDR_W;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);
   localparam logic [1:0]       RESP_OK  = 2'b00;
   localparam logic [1:0]       RESP_ERR = 2'b10;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      RWAIT = 3'd1,
      RRESP = 3'd2,
      WWAIT = 3'd3,
      WRESP = 3'd4
   } state_t;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [31:0]       addr_q, addr_d;
   logic [31:0]       wdata_q, wdata_d;
   logic [3:0]        wstrb_q, wstrb_d;
   logic [31:0]       rdata_q, rdata_d;
   logic [1:0]        rresp_q, rresp_d;
   logic [1:0]        bresp_q, bresp_d;
   logic              mem_we;
   logic              in_range;
   logic              rd_go;
   logic              wr_go;
   logic [ADDR_W-1:0] idx;
   logic              unused_addr_lsbs;
   logic [31:0]       mem [DEPTH];

   // Byte offset within the word is left to the requester.
   assign unused_addr_lsbs = ^addr_q[1:0];
   assign in_range         = (addr_q[31:ADDR_W+2] == BASE[31:ADDR_W+2]);
   assign idx              = addr_q[ADDR_W+1:2];

   assign rd_go   = (state_q == IDLE) && arvalid;
   assign wr_go   = (state_q == IDLE) && awvalid && wvalid && !arvalid;
   assign arready = (state_q == IDLE) && !rst;
   assign awready = wr_go && !rst;
   assign wready  = wr_go && !rst;
   assign rvalid  = (state_q == RRESP);
   assign bvalid  = (state_q == WRESP);
   assign rdata   = rdata_q;
   assign rresp   = rresp_q;
   assign bresp   = bresp_q;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      wstrb_d = wstrb_q;
      rdata_d = rdata_q;
      rresp_d = rresp_q;
      bresp_d = bresp_q;
      mem_we  = 1'b0;
      case (state_q)
         IDLE: begin
            if (rd_go) begin
               addr_d  = araddr;
               cnt_d   = CNT_LOAD;
               state_d = RWAIT;
            end else if (wr_go) begin
               addr_d  = awaddr;
               wdata_d = wdata;
               wstrb_d = wstrb;
               cnt_d   = CNT_LOAD;
               state_d = WWAIT;
            end
         end
         RWAIT: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - 1'b1;
            end else begin
               rdata_d = in_range ? mem[idx] : 32'h0;
               rresp_d = in_range ? RESP_OK : RESP_ERR;
               state_d = RRESP;
            end
         end
         RRESP: begin
            if (rready) state_d = IDLE;
         end
         WWAIT: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - 1'b1;
            end else begin
               // A reset on the commit edge discards the write.
               mem_we  = in_range && !rst;
               bresp_d = in_range ? RESP_OK : RESP_ERR;
               state_d = WRESP;
            end
         end
         WRESP: begin
            if (bready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         wstrb_q <= '0;
         rdata_q <= '0;
         rresp_q <= RESP_OK;
         bresp_q <= RESP_OK;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         wstrb_q <= wstrb_d;
         rdata_q <= rdata_d;
         rresp_q <= rresp_d;
         bresp_q <= bresp_d;
      end
   end

   // Storage is deliberately not reset.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         for (int i = 0; i < 4; i++) begin
            if (wstrb_q[i]) mem[idx][8*i +: 8] <= wdata_q[8*i +: 8];
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_dmem_sram_resp.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_dmem_sram_resp : directed stimulus checked against a            |
// |                     transaction-level memory model                 |
// | Revision          : 1.0                                            |
// +--------------------------------------------------------------------+
module tb_dmem_sram_resp;

   localparam int unsigned LAT  = 2;
   localparam logic [31:0] BASE = 32'h8000_0000;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] araddr = '0, awaddr = '0, wdata = '0;
   logic        arvalid = 1'b0, rready = 1'b0, awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0;
   logic [3:0]  wstrb = '0;
   logic [31:0] rdata;
   logic [1:0]  rresp, bresp;
   logic        arready, rvalid, awready, wready, bvalid;

   logic        l_arvalid = 1'b0;
   logic        l1_arready, l1_rvalid, l1_awready, l1_wready, l1_bvalid;
   logic        l4_arready, l4_rvalid, l4_awready, l4_wready, l4_bvalid;
   logic [31:0] l1_rdata, l4_rdata;
   logic [1:0]  l1_rresp, l1_bresp, l4_rresp, l4_bresp;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   always #5 clk = ~clk;
   initial forever begin
      @(posedge clk);
      cyc++;
   end

   dmem_sram_resp #(.ADDR_W(8), .BASE(BASE), .LATENCY(LAT)) u_dut (
      .clk(clk), .rst(rst),
      .araddr(araddr), .arvalid(arvalid), .arready(arready),
      .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
      .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
      .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
      .bresp(bresp), .bvalid(bvalid), .bready(bready)
   );

   dmem_sram_resp #(.ADDR_W(8), .BASE(BASE), .LATENCY(1)) u_lat1 (
      .clk(clk), .rst(rst),
      .araddr(32'h0), .arvalid(l_arvalid), .arready(l1_arready),
      .rdata(l1_rdata), .rresp(l1_rresp), .rvalid(l1_rvalid), .rready(1'b1),
      .awaddr(32'h0), .awvalid(1'b0), .awready(l1_awready),
      .wdata(32'h0), .wstrb(4'h0), .wvalid(1'b0), .wready(l1_wready),
      .bresp(l1_bresp), .bvalid(l1_bvalid), .bready(1'b1)
   );

   dmem_sram_resp #(.ADDR_W(8), .BASE(BASE), .LATENCY(4)) u_lat4 (
      .clk(clk), .rst(rst),
      .araddr(32'h0), .arvalid(l_arvalid), .arready(l4_arready),
      .rdata(l4_rdata), .rresp(l4_rresp), .rvalid(l4_rvalid), .rready(1'b1),
      .awaddr(32'h0), .awvalid(1'b0), .awready(l4_awready),
      .wdata(32'h0), .wstrb(4'h0), .wvalid(1'b0), .wready(l4_wready),
      .bresp(l4_bresp), .bvalid(l4_bvalid), .bready(1'b1)
   );

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   task automatic timeout(input string name);
      checks++;
      errors++;
      $display("FAIL %s: timed out waiting (cycle %0d)", name, cyc);
   endtask

   // Reference model: one outstanding transaction, response due LAT+1 cycles
   // after acceptance, memory updated on the cycle before the response.
   logic [31:0] mm [256];
   bit          m_busy = 1'b0, m_rd = 1'b0, m_done = 1'b0;
   int          m_due  = 0;
   logic [31:0] m_addr, m_wdata, m_exp_data;
   logic [3:0]  m_wstrb;
   logic [1:0]  m_exp_resp;

   function automatic bit in_rng(input logic [31:0] a);
      return a[31:10] == BASE[31:10];
   endfunction

   initial forever begin
      @(negedge clk);
      if (rst) begin
         chk("arready_in_reset", 32'(arready), 32'd0);
         chk("awready_in_reset", 32'(awready), 32'd0);
         chk("wready_in_reset",  32'(wready),  32'd0);
         m_busy = 1'b0;
      end else begin
         chk("arready", 32'(arready), 32'(!m_busy));
         chk("awready", 32'(awready), 32'(!m_busy && awvalid && wvalid && !arvalid));
         chk("wready",  32'(wready),  32'(!m_busy && awvalid && wvalid && !arvalid));
         chk("rvalid",  32'(rvalid),  32'(m_busy && m_rd && cyc >= m_due));
         chk("bvalid",  32'(bvalid),  32'(m_busy && !m_rd && cyc >= m_due));
         if (m_busy && cyc >= m_due) begin
            if (m_rd) begin
               chk("rdata", rdata, m_exp_data);
               chk("rresp", 32'(rresp), 32'(m_exp_resp));
            end else begin
               chk("bresp", 32'(bresp), 32'(m_exp_resp));
            end
         end
         if (m_busy && !m_rd && !m_done && cyc == m_due - 1) begin
            m_done = 1'b1;
            if (in_rng(m_addr)) begin
               for (int i = 0; i < 4; i++)
                  if (m_wstrb[i]) mm[m_addr[9:2]][8*i +: 8] = m_wdata[8*i +: 8];
            end
         end
         if (m_busy && cyc >= m_due && (m_rd ? rready : bready)) begin
            m_busy = 1'b0;
         end else if (!m_busy && arvalid) begin
            m_busy     = 1'b1;
            m_rd       = 1'b1;
            m_due      = cyc + LAT + 1;
            m_exp_data = in_rng(araddr) ? mm[araddr[9:2]] : 32'h0;
            m_exp_resp = in_rng(araddr) ? 2'b00 : 2'b10;
         end else if (!m_busy && awvalid && wvalid) begin
            m_busy     = 1'b1;
            m_rd       = 1'b0;
            m_done     = 1'b0;
            m_due      = cyc + LAT + 1;
            m_addr     = awaddr;
            m_wdata    = wdata;
            m_wstrb    = wstrb;
            m_exp_resp = in_rng(awaddr) ? 2'b00 : 2'b10;
         end
      end
   end

   task automatic do_read(input logic [31:0] a, input int hold,
                          output logic [31:0] d, output logic [1:0] r,
                          output int lat, output int hs);
      bit ok = 1'b0;
      int c0;
      araddr  = a;
      arvalid = 1'b1;
      rready  = (hold == 0);
      for (int i = 0; i < 20 && !ok; i++) begin
         @(negedge clk);
         if (arready) ok = 1'b1;
      end
      if (!ok) timeout("read_accept");
      c0 = cyc;
      @(posedge clk); #1;
      arvalid = 1'b0;
      ok = 1'b0;
      for (int i = 0; i < 20 && !ok; i++) begin
         @(negedge clk);
         if (rvalid) ok = 1'b1;
      end
      if (!ok) timeout("read_response");
      lat = cyc - c0;
      d   = rdata;
      r   = rresp;
      if (hold > 0) begin
         repeat (hold) @(posedge clk);
         #1 rready = 1'b1;
         @(negedge clk);
      end
      hs = cyc;
      @(posedge clk); #1;
      rready = 1'b0;
   endtask

   task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           output logic [1:0] r, output int lat);
      bit ok = 1'b0;
      int c0;
      awaddr  = a;
      wdata   = d;
      wstrb   = s;
      awvalid = 1'b1;
      wvalid  = 1'b1;
      bready  = 1'b1;
      for (int i = 0; i < 20 && !ok; i++) begin
         @(negedge clk);
         if (awready && wready) ok = 1'b1;
      end
      if (!ok) timeout("write_accept");
      c0 = cyc;
      @(posedge clk); #1;
      awvalid = 1'b0;
      wvalid  = 1'b0;
      ok = 1'b0;
      for (int i = 0; i < 20 && !ok; i++) begin
         @(negedge clk);
         if (bvalid) ok = 1'b1;
      end
      if (!ok) timeout("write_response");
      lat = cyc - c0;
      r   = bresp;
      @(posedge clk); #1;
   endtask

   initial begin
      logic [31:0] d;
      logic [1:0]  r;
      int          lat, hs, c0, lat1, lat4;
      bit          ok;

      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("post_reset_arready", 32'(arready), 32'd1);
      chk("post_reset_rvalid",  32'(rvalid),  32'd0);
      chk("post_reset_rdata",   rdata,        32'd0);
      chk("post_reset_bresp",   32'(bresp),   32'd0);
      @(posedge clk); #1;

      do_write(32'h8000_0010, 32'hDEAD_BEEF, 4'hF, r, lat);
      chk("wr_full_bresp", 32'(r), 32'd0);
      chk("wr_latency", 32'(lat), 32'd3);
      do_read(32'h8000_0010, 0, d, r, lat, hs);
      chk("rd_full_data", d, 32'hDEAD_BEEF);
      chk("rd_full_resp", 32'(r), 32'd0);
      chk("rd_latency", 32'(lat), 32'd3);
      do_read(32'h8000_0013, 0, d, r, lat, hs);
      chk("rd_unaligned_data", d, 32'hDEAD_BEEF);

      do_write(32'h8000_0020, 32'h1122_3344, 4'hF, r, lat);
      chk("wr_base_bresp", 32'(r), 32'd0);
      do_write(32'h8000_0020, 32'h0000_00AA, 4'h1, r, lat);
      chk("wr_lane0_bresp", 32'(r), 32'd0);
      do_write(32'h8000_0020, 32'h0000_BB00, 4'h2, r, lat);
      chk("wr_lane1_bresp", 32'(r), 32'd0);
      do_write(32'h8000_0020, 32'hFFFF_FFFF, 4'h0, r, lat);
      chk("wr_nostrb_bresp", 32'(r), 32'd0);
      do_read(32'h8000_0020, 0, d, r, lat, hs);
      chk("rd_merged_data", d, 32'h1122_BBAA);

      do_read(32'h0000_0000, 0, d, r, lat, hs);
      chk("rd_oor_data", d, 32'h0);
      chk("rd_oor_resp", 32'(r), 32'd2);
      do_write(32'h8000_0000, 32'hCAFE_F00D, 4'hF, r, lat);
      do_write(32'h9000_0000, 32'h1234_5678, 4'hF, r, lat);
      chk("wr_oor_bresp", 32'(r), 32'd2);
      do_read(32'h8000_0000, 0, d, r, lat, hs);
      chk("rd_alias_data", d, 32'hCAFE_F00D);

      do_read(32'h8000_0010, 5, d, r, lat, hs);
      chk("rd_hold_data", d, 32'hDEAD_BEEF);
      @(negedge clk);
      chk("after_hold_rvalid",  32'(rvalid),  32'd0);
      chk("after_hold_arready", 32'(arready), 32'd1);
      @(posedge clk); #1;

      // Read and write presented together: read wins, write follows.
      awaddr = 32'h8000_0040; wdata = 32'h0000_0055; wstrb = 4'hF;
      awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
      do_read(32'h8000_0010, 0, d, r, lat, hs);
      chk("rd_priority_data", d, 32'hDEAD_BEEF);
      ok = 1'b0;
      for (int i = 0; i < 20 && !ok; i++) begin
         @(negedge clk);
         if (awready) ok = 1'b1;
      end
      if (!ok) timeout("deferred_write_accept");
      chk("deferred_write_gap", 32'(cyc - hs), 32'd1);
      @(posedge clk); #1;
      awvalid = 1'b0; wvalid = 1'b0;
      repeat (LAT + 2) @(posedge clk);
      #1;
      do_read(32'h8000_0040, 0, d, r, lat, hs);
      chk("rd_deferred_data", d, 32'h0000_0055);

      // Reset while the write is still waiting: the write must be lost.
      awaddr = 32'h8000_0020; wdata = 32'hFFFF_FFFF; wstrb = 4'hF;
      awvalid = 1'b1; wvalid = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 20 && !ok; i++) begin
         @(negedge clk);
         if (awready) ok = 1'b1;
      end
      if (!ok) timeout("rst_write_accept");
      @(posedge clk); #1;
      awvalid = 1'b0; wvalid = 1'b0; rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("midrst_bvalid",  32'(bvalid),  32'd0);
      chk("midrst_rvalid",  32'(rvalid),  32'd0);
      chk("midrst_rdata",   rdata,        32'd0);
      chk("midrst_bresp",   32'(bresp),   32'd0);
      chk("midrst_arready", 32'(arready), 32'd1);
      @(posedge clk); #1;
      do_read(32'h8000_0020, 0, d, r, lat, hs);
      chk("rd_after_rst_data", d, 32'h1122_BBAA);

      // Latency 1 and 4 instances, both idle, both fed one out-of-range read.
      l_arvalid = 1'b1;
      @(negedge clk);
      chk("lat1_arready", 32'(l1_arready), 32'd1);
      chk("lat4_arready", 32'(l4_arready), 32'd1);
      c0 = cyc;
      lat1 = -1;
      lat4 = -1;
      @(posedge clk); #1;
      l_arvalid = 1'b0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (l1_rvalid && lat1 < 0) begin
            lat1 = cyc - c0;
            chk("lat1_rresp", 32'(l1_rresp), 32'd2);
         end
         if (l4_rvalid && lat4 < 0) begin
            lat4 = cyc - c0;
            chk("lat4_rresp", 32'(l4_rresp), 32'd2);
         end
      end
      chk("lat1_first_rvalid", 32'(lat1), 32'd2);
      chk("lat4_first_rvalid", 32'(lat4), 32'd5);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
